// File: rtl/rasterizer_mem_arbiter.sv
// Two-port round-robin arbiter sharing one SDRAM Avalon-MM master; reads are routed back via an in-order tag ring.
// Zero-cycle command path; grant held across m_waitrequest; sN_waitrequest low only in the acceptance cycle.
module rasterizer_mem_arbiter #(
    parameter int ADDR_W      = 26,
    parameter int DATA_W      = 32,
    parameter int MAX_PENDING = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [ADDR_W-1:0]             s0_address,
    input  logic                          s0_read,
    input  logic                          s0_write,
    input  logic [DATA_W/8-1:0]           s0_byteenable,
    input  logic [DATA_W-1:0]             s0_writedata,
    output logic                          s0_waitrequest,
    output logic [DATA_W-1:0]             s0_readdata,
    output logic                          s0_readdatavalid,
    input  logic [ADDR_W-1:0]             s1_address,
    input  logic                          s1_read,
    input  logic                          s1_write,
    input  logic [DATA_W/8-1:0]           s1_byteenable,
    input  logic [DATA_W-1:0]             s1_writedata,
    output logic                          s1_waitrequest,
    output logic [DATA_W-1:0]             s1_readdata,
    output logic                          s1_readdatavalid,
    output logic [ADDR_W-1:0]             m_address,
    output logic                          m_read,
    output logic                          m_write,
    output logic [DATA_W/8-1:0]           m_byteenable,
    output logic [DATA_W-1:0]             m_writedata,
    input  logic                          m_waitrequest,
    input  logic [DATA_W-1:0]             m_readdata,
    input  logic                          m_readdatavalid,
    output logic [$clog2(MAX_PENDING):0]  pending_count,
    output logic                          protocol_error
);
    localparam int BE_W  = DATA_W / 8;
    localparam int PTR_W = $clog2(MAX_PENDING);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING);

    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]       state_q, state_d;
    logic             rr_last_q, rr_last_d;
    logic             grant_q, grant_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             err_q, err_d;
    logic             tag_mem_q [MAX_PENDING];
    logic [ADDR_W-1:0] addr_q;
    logic [BE_W-1:0]   be_q;
    logic [DATA_W-1:0] wdata_q;

    logic [1:0] req_rd, req_wr, elig;
    logic       read_ok;
    logic       sel, sel_vld, sel_rd, sel_wr;
    logic       accept, push, pop, stray, illegal, head_tag;
    logic [ADDR_W-1:0] sel_addr;
    logic [BE_W-1:0]   sel_be;
    logic [DATA_W-1:0] sel_wdata;

    assign req_rd  = {s1_read, s0_read};
    assign req_wr  = {s1_write, s0_write};
    // Blocking uses the registered count, so a slot freed this cycle only opens next cycle.
    assign read_ok = (pend_q < CNT_MAX);
    assign elig    = req_wr | (req_rd & {2{read_ok}});

    always_comb begin
        sel     = rr_last_q;
        sel_vld = 1'b0;
        if (state_q == ST_HOLD) begin
            sel     = grant_q;
            sel_vld = req_rd[grant_q] | req_wr[grant_q];
        end else if (elig[~rr_last_q]) begin
            sel     = ~rr_last_q;
            sel_vld = 1'b1;
        end else if (elig[rr_last_q]) begin
            sel     = rr_last_q;
            sel_vld = 1'b1;
        end
    end

    // Read+write on one port is resolved as a write.
    assign sel_wr    = sel_vld & req_wr[sel];
    assign sel_rd    = sel_vld & req_rd[sel] & ~req_wr[sel];
    assign accept    = sel_vld & ~m_waitrequest;
    assign push      = accept & sel_rd;
    assign pop       = m_readdatavalid & (pend_q != '0);
    assign stray     = m_readdatavalid & (pend_q == '0);
    assign illegal   = (s0_read & s0_write) | (s1_read & s1_write);
    assign head_tag  = tag_mem_q[rd_ptr_q];

    assign sel_addr  = sel ? s1_address   : s0_address;
    assign sel_be    = sel ? s1_byteenable : s0_byteenable;
    assign sel_wdata = sel ? s1_writedata : s0_writedata;

    assign m_address    = sel_vld ? sel_addr  : addr_q;
    assign m_byteenable = sel_vld ? sel_be    : be_q;
    assign m_writedata  = sel_vld ? sel_wdata : wdata_q;
    assign m_read       = reset & sel_rd;
    assign m_write      = reset & sel_wr;

    assign s0_waitrequest   = ~(reset & accept & ~sel);
    assign s1_waitrequest   = ~(reset & accept & sel);
    assign s0_readdata      = m_readdata;
    assign s1_readdata      = m_readdata;
    assign s0_readdatavalid = reset & pop & ~head_tag;
    assign s1_readdatavalid = reset & pop & head_tag;

    assign pending_count  = pend_q;
    assign protocol_error = err_q;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_last_d = rr_last_q;
        case (state_q)
            ST_ARB: begin
                if (sel_vld && m_waitrequest) begin
                    state_d = ST_HOLD;
                    grant_d = sel;
                end
            end
            default: begin
                if (!sel_vld || accept) begin
                    state_d = ST_ARB;
                end
            end
        endcase
        if (accept) begin
            rr_last_d = sel;
        end
    end

    always_comb begin
        pend_d = pend_q;
        case ({push, pop})
            2'b10:   pend_d = pend_q + CNT_W'(1);
            2'b01:   pend_d = pend_q - CNT_W'(1);
            default: pend_d = pend_q;
        endcase
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        err_d    = err_q | illegal | stray;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_ARB;
            rr_last_q <= 1'b1;
            grant_q   <= 1'b0;
            pend_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            grant_q   <= grant_d;
            pend_q    <= pend_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            err_q     <= err_d;
            if (sel_vld) begin
                addr_q  <= sel_addr;
                be_q    <= sel_be;
                wdata_q <= sel_wdata;
            end
        end
    end

    // Tag storage needs no reset: entries are only read behind a nonzero count.
    always_ff @(posedge clock) begin
        if (push) begin
            tag_mem_q[wr_ptr_q] <= sel;
        end
    end
endmodule

// File: tb/tb_rasterizer_mem_arbiter.sv
// Randomized plus directed bench for rasterizer_mem_arbiter against a queue-based transaction model.
module tb_rasterizer_mem_arbiter;
    localparam int AW = 26;
    localparam int DW = 32;
    localparam int MAXP = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic          c_rd [2];
    logic          c_wr [2];
    logic [AW-1:0] c_addr [2];
    logic [DW-1:0] c_wd [2];
    logic [3:0]    c_be [2];
    logic          mwait, rdv;
    logic [DW-1:0] mrdata;

    logic          s0_waitrequest, s1_waitrequest, s0_readdatavalid, s1_readdatavalid;
    logic [DW-1:0] s0_readdata, s1_readdata, m_writedata;
    logic [AW-1:0] m_address;
    logic          m_read, m_write, protocol_error;
    logic [3:0]    m_byteenable;
    logic [3:0]    pending_count;

    rasterizer_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_PENDING(MAXP)) dut (
        .clock(clock), .reset(reset),
        .s0_address(c_addr[0]), .s0_read(c_rd[0]), .s0_write(c_wr[0]),
        .s0_byteenable(c_be[0]), .s0_writedata(c_wd[0]),
        .s0_waitrequest(s0_waitrequest), .s0_readdata(s0_readdata), .s0_readdatavalid(s0_readdatavalid),
        .s1_address(c_addr[1]), .s1_read(c_rd[1]), .s1_write(c_wr[1]),
        .s1_byteenable(c_be[1]), .s1_writedata(c_wd[1]),
        .s1_waitrequest(s1_waitrequest), .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
        .m_address(m_address), .m_read(m_read), .m_write(m_write),
        .m_byteenable(m_byteenable), .m_writedata(m_writedata),
        .m_waitrequest(mwait), .m_readdata(mrdata), .m_readdatavalid(rdv),
        .pending_count(pending_count), .protocol_error(protocol_error)
    );

    int total = 0;
    int bad = 0;

    // Transaction-level model: last served port, pending grant, queue of outstanding read owners.
    int m_rr = 1;
    bit m_hold = 0;
    int m_grant = 0;
    bit m_err = 0;
    int tagq[$];
    int last_acc;
    logic [1:0] last_rdv;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        int sel;
        bit acc, erd, ewr;
        logic [1:0] el;
        logic [1:0] exp_rdv;
        #1;
        for (int n = 0; n < 2; n++)
            el[n] = c_wr[n] | (c_rd[n] && (tagq.size() < MAXP));
        sel = -1;
        if (m_hold) begin
            if (c_rd[m_grant] || c_wr[m_grant]) sel = m_grant;
        end else if (el[1 - m_rr]) sel = 1 - m_rr;
        else if (el[m_rr]) sel = m_rr;
        ewr = (sel >= 0) && c_wr[sel];
        erd = (sel >= 0) && c_rd[sel] && !c_wr[sel];
        acc = (sel >= 0) && !mwait;
        exp_rdv = 2'b00;
        if (rdv && tagq.size() > 0) exp_rdv[tagq[0]] = 1'b1;

        chk("m_read", m_read, erd);
        chk("m_write", m_write, ewr);
        if (sel >= 0) begin
            chk("m_address", m_address, c_addr[sel]);
            chk("m_byteenable", m_byteenable, c_be[sel]);
            if (ewr) chk("m_writedata", m_writedata, c_wd[sel]);
        end
        chk("s0_waitrequest", s0_waitrequest, !(acc && sel == 0));
        chk("s1_waitrequest", s1_waitrequest, !(acc && sel == 1));
        chk("readdatavalid", {s1_readdatavalid, s0_readdatavalid}, exp_rdv);
        if (rdv) begin
            chk("s0_readdata", s0_readdata, mrdata);
            chk("s1_readdata", s1_readdata, mrdata);
        end
        chk("pending_count", pending_count, tagq.size());
        chk("protocol_error", protocol_error, m_err);
        last_rdv = {s1_readdatavalid, s0_readdatavalid};

        if (rdv) begin
            if (tagq.size() > 0) void'(tagq.pop_front());
            else m_err = 1;
        end
        for (int n = 0; n < 2; n++) if (c_rd[n] && c_wr[n]) m_err = 1;
        if (acc) begin
            m_rr = sel;
            if (erd) tagq.push_back(sel);
        end
        if (!m_hold && sel >= 0 && mwait) begin
            m_hold = 1;
            m_grant = sel;
        end else if (m_hold && (sel < 0 || acc)) begin
            m_hold = 0;
        end
        last_acc = acc ? sel : -1;
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_m_read", m_read, 1'b0);
        chk("rst_m_write", m_write, 1'b0);
        chk("rst_s0_wait", s0_waitrequest, 1'b1);
        chk("rst_s1_wait", s1_waitrequest, 1'b1);
        chk("rst_rdv", {s1_readdatavalid, s0_readdatavalid}, 2'b00);
        chk("rst_pending", pending_count, 0);
        chk("rst_error", protocol_error, 1'b0);
        tagq.delete();
        m_rr = 1;
        m_hold = 0;
        m_err = 0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic set_cmd(input int n, input bit rd, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        c_rd[n] = rd;
        c_wr[n] = wr;
        c_addr[n] = a;
        c_wd[n] = d;
        c_be[n] = 4'hF;
    endtask

    task automatic idle_all();
        set_cmd(0, 0, 0, '0, '0);
        set_cmd(1, 0, 0, '0, '0);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        idle_all();
        mwait = 0;
        while (tagq.size() > 0 && guard < 50) begin
            rdv = 1;
            mrdata = $urandom;
            step();
            guard++;
        end
        rdv = 0;
        chk("drain_empty", pending_count, 0);
    endtask

    task automatic rand_cmd(input int n);
        bit rd;
        rd = (n == 0) ? ($urandom_range(0, 99) < 80) : ($urandom_range(0, 99) < 30);
        set_cmd(n, rd, !rd, AW'($urandom), $urandom);
        c_be[n] = 4'($urandom);
    endtask

    initial begin
        int prev;
        idle_all();
        mwait = 0;
        rdv = 0;
        mrdata = '0;
        @(negedge clock);
        c_rd[0] = 1;
        rdv = 1;
        do_reset();
        rdv = 0;
        idle_all();

        // s0 back-to-back reads, then in-order responses
        for (int i = 0; i < 3; i++) begin
            set_cmd(0, 1, 0, AW'(32'h100 + 4 * i), '0);
            step();
            chk("tp1_accept", last_acc, 0);
        end
        idle_all();
        for (int i = 0; i < 3; i++) begin
            rdv = 1;
            mrdata = 32'hD000_0000 + i;
            step();
            chk("tp1_rdv", last_rdv, 2'b01);
        end
        rdv = 0;

        // both ports contending: grants alternate
        set_cmd(0, 1, 0, AW'(32'h100), '0);
        set_cmd(1, 0, 1, AW'(32'h200), 32'hDEADBEEF);
        prev = -1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i > 0) chk("tp2_alternate", last_acc != prev, 1'b1);
            prev = last_acc;
        end
        drain();

        // s1 held through waitrequest while s0 waits
        set_cmd(0, 1, 0, AW'(32'h300), '0);
        step();
        chk("tp3_pre", last_acc, 0);
        set_cmd(1, 0, 1, AW'(32'h200), 32'hDEADBEEF);
        mwait = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("tp3_hold_addr", m_address, AW'(32'h200));
        end
        mwait = 0;
        step();
        chk("tp3_accept_s1", last_acc, 1);
        set_cmd(1, 0, 0, '0, '0);
        step();
        chk("tp3_then_s0", last_acc, 0);
        drain();

        // MAX_PENDING boundary
        for (int i = 0; i < MAXP; i++) begin
            set_cmd(0, 1, 0, AW'(32'h400 + 4 * i), '0);
            step();
        end
        chk("tp4_full", pending_count, MAXP);
        set_cmd(1, 0, 1, AW'(32'h500), 32'h1234_5678);
        step();
        chk("tp4_write_ok", last_acc, 1);
        set_cmd(1, 0, 0, '0, '0);
        rdv = 1;
        step();
        chk("tp4_blocked_on_free", last_acc, -1);
        rdv = 0;
        step();
        chk("tp4_read_after_free", last_acc, 0);
        drain();

        // interleaved read owners return in order
        set_cmd(0, 1, 0, AW'(32'h600), '0);
        step();
        set_cmd(0, 0, 0, '0, '0);
        set_cmd(1, 1, 0, AW'(32'h604), '0);
        step();
        set_cmd(1, 0, 0, '0, '0);
        set_cmd(0, 1, 0, AW'(32'h608), '0);
        step();
        idle_all();
        rdv = 1;
        step();
        chk("tp5_r0", last_rdv, 2'b01);
        step();
        chk("tp5_r1", last_rdv, 2'b10);
        step();
        chk("tp5_r2", last_rdv, 2'b01);
        rdv = 0;

        // reset with reads outstanding
        for (int i = 0; i < 3; i++) begin
            set_cmd(0, 1, 0, AW'(32'h700 + 4 * i), '0);
            step();
        end
        do_reset();
        idle_all();

        // randomized traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            mwait = ($urandom_range(0, 99) < 30);
            rdv = (tagq.size() > 0) && ($urandom_range(0, 99) < 40);
            mrdata = $urandom;
            for (int n = 0; n < 2; n++) begin
                if (!c_rd[n] && !c_wr[n]) begin
                    if ($urandom_range(0, 1) == 1) rand_cmd(n);
                end else if ($urandom_range(0, 99) < 3) begin
                    set_cmd(n, 0, 0, c_addr[n], c_wd[n]);
                end
            end
            step();
            if (last_acc >= 0) begin
                if ($urandom_range(0, 1) == 1) rand_cmd(last_acc);
                else set_cmd(last_acc, 0, 0, '0, '0);
            end
        end
        rdv = 0;
        drain();

        // stray response is sticky until reset
        rdv = 1;
        step();
        rdv = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stray_sticky", protocol_error, 1'b1);
        end
        do_reset();

        // read and write together behaves as a write and flags an error
        set_cmd(0, 1, 1, AW'(32'h800), 32'hCAFE_F00D);
        step();
        chk("illegal_as_write", last_acc, 0);
        idle_all();
        step();
        chk("illegal_flag", protocol_error, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
